// File: rtl/sd_avs_arbiter.sv
// N-master Avalon arbiter in front of the single driver_sd slave (4-word register window).
// One transaction in flight; disabled masters and out-of-window addresses are completed locally.
module sd_avs_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SLAVE_ADDR_W = 2,
    parameter int READ_LATENCY = 1,
    parameter int RR_MODE      = 0
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_enable,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [NUM_MASTERS*DATA_W-1:0] m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [SLAVE_ADDR_W-1:0]       driver_sd_avs_address,
    output logic                          driver_sd_avs_read,
    output logic                          driver_sd_avs_write,
    output logic [DATA_W-1:0]             driver_sd_avs_writedata,
    input  logic [DATA_W-1:0]             driver_sd_avs_readdata,
    input  logic                          driver_sd_avs_waitrequest
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t                          r_state;
    logic [GW-1:0]                   r_last_grant;
    logic [NUM_MASTERS-1:0]          r_gnt_oh;
    logic [SLAVE_ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]               r_wdata;
    logic                            r_is_write;
    logic [1:0]                      r_lat;
    logic [NUM_MASTERS*DATA_W-1:0]   r_readdata;
    logic [NUM_MASTERS-1:0]          r_rvalid;

    logic [NUM_MASTERS-1:0]          w_req;
    logic [31:0]                     w_base;
    logic [GW-1:0]                   w_grant;
    logic                            w_grant_vld;
    logic [NUM_MASTERS-1:0]          w_grant_oh;
    logic [ADDR_W-1:0]               w_sel_addr;
    logic [DATA_W-1:0]               w_sel_wdata;
    logic                            w_sel_write;
    logic                            w_sel_en;
    logic                            w_local;
    logic                            w_accept;
    logic                            w_issue;

    // A simultaneous read+write counts as a single write request
    assign w_req  = m_read | m_write;
    assign w_base = (RR_MODE != 0) ? (32'(r_last_grant) + 32'd1) : 32'd0;

    // Search order starts at w_base and wraps; fixed priority is simply base 0
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_grant_oh  = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!w_grant_vld && w_req[i] && (i == (w_base + k) % NUM_MASTERS)) begin
                    w_grant       = GW'(i);
                    w_grant_vld   = 1'b1;
                    w_grant_oh[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        w_sel_en    = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_addr  = m_address[i*ADDR_W +: ADDR_W];
                w_sel_wdata = m_writedata[i*DATA_W +: DATA_W];
                w_sel_write = m_write[i];
                w_sel_en    = m_enable[i];
            end
        end
    end

    assign w_local  = !w_sel_en || (|(w_sel_addr >> (SLAVE_ADDR_W + 2)));
    assign w_accept = (r_state == IDLE) && w_grant_vld;
    assign w_issue  = (r_state == ISSUE);

    assign m_waitrequest = w_req & ~({NUM_MASTERS{r_state == IDLE}} & w_grant_oh);

    assign driver_sd_avs_read      = w_issue & ~r_is_write;
    assign driver_sd_avs_write     = w_issue & r_is_write;
    assign driver_sd_avs_address   = w_issue ? r_addr : '0;
    assign driver_sd_avs_writedata = w_issue ? r_wdata : '0;

    assign m_readdata      = r_readdata;
    assign m_readdatavalid = r_rvalid;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GW'(NUM_MASTERS - 1);
            r_gnt_oh     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_lat        <= '0;
            r_readdata   <= '0;
            r_rvalid     <= '0;
        end else begin
            r_rvalid   <= '0;
            r_readdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                        r_gnt_oh     <= w_grant_oh;
                        r_addr       <= w_sel_addr[SLAVE_ADDR_W+1:2];
                        r_wdata      <= w_sel_wdata;
                        r_is_write   <= w_sel_write;
                        if (!w_local) begin
                            r_state <= ISSUE;
                        end else if (!w_sel_write) begin
                            // Local read answers with the zero readdata left by the default above
                            r_rvalid <= w_grant_oh;
                            r_state  <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (!driver_sd_avs_waitrequest) begin
                        if (r_is_write) begin
                            r_state <= IDLE;
                        end else begin
                            r_lat   <= 2'(READ_LATENCY - 1);
                            r_state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (r_lat == 2'd0) begin
                        r_rvalid <= r_gnt_oh;
                        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                            r_readdata[i*DATA_W +: DATA_W] <= {DATA_W{r_gnt_oh[i]}} & driver_sd_avs_readdata;
                        end
                        r_state <= RESP;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_avs_arbiter.sv
// Directed bench for sd_avs_arbiter: fixed-priority, round-robin and latency-3 instances
// share one stimulus; each phase checks the instance whose behaviour it targets.
module tb_sd_avs_arbiter;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;
    localparam logic [63:0] Z64 = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en = '0, rd = '0, wr = '0;
    logic [63:0] addr = '0, wdata = '0;
    logic        swait = 1'b0;
    logic [31:0] srdata = '0;

    logic [1:0]  fp_wait, fp_rv, fp_sa, rr_wait, rr_rv, rr_sa, l3_wait, l3_rv, l3_sa;
    logic [63:0] fp_rd, rr_rd, l3_rd;
    logic        fp_sr, fp_sw, rr_sr, rr_sw, l3_sr, l3_sw;
    logic [31:0] fp_swd, rr_swd, l3_swd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sd_avs_arbiter #(.NUM_MASTERS(2), .READ_LATENCY(1), .RR_MODE(0)) u_fp (
        .clk_sys(clk), .rst(rst), .m_enable(en), .m_address(addr), .m_read(rd), .m_write(wr),
        .m_writedata(wdata), .m_readdata(fp_rd), .m_readdatavalid(fp_rv), .m_waitrequest(fp_wait),
        .driver_sd_avs_address(fp_sa), .driver_sd_avs_read(fp_sr), .driver_sd_avs_write(fp_sw),
        .driver_sd_avs_writedata(fp_swd), .driver_sd_avs_readdata(srdata),
        .driver_sd_avs_waitrequest(swait));

    sd_avs_arbiter #(.NUM_MASTERS(2), .READ_LATENCY(1), .RR_MODE(1)) u_rr (
        .clk_sys(clk), .rst(rst), .m_enable(en), .m_address(addr), .m_read(rd), .m_write(wr),
        .m_writedata(wdata), .m_readdata(rr_rd), .m_readdatavalid(rr_rv), .m_waitrequest(rr_wait),
        .driver_sd_avs_address(rr_sa), .driver_sd_avs_read(rr_sr), .driver_sd_avs_write(rr_sw),
        .driver_sd_avs_writedata(rr_swd), .driver_sd_avs_readdata(srdata),
        .driver_sd_avs_waitrequest(swait));

    sd_avs_arbiter #(.NUM_MASTERS(2), .READ_LATENCY(3), .RR_MODE(0)) u_l3 (
        .clk_sys(clk), .rst(rst), .m_enable(en), .m_address(addr), .m_read(rd), .m_write(wr),
        .m_writedata(wdata), .m_readdata(l3_rd), .m_readdatavalid(l3_rv), .m_waitrequest(l3_wait),
        .driver_sd_avs_address(l3_sa), .driver_sd_avs_read(l3_sr), .driver_sd_avs_write(l3_sw),
        .driver_sd_avs_writedata(l3_swd), .driver_sd_avs_readdata(srdata),
        .driver_sd_avs_waitrequest(swait));

    typedef struct {
        logic [1:0]  en, rd, wr;
        logic [63:0] addr, wdata;
        logic        swait;
        logic [31:0] srdata;
        logic [1:0]  x_wait, x_rv;
        logic [63:0] x_rd;
        logic [63:0] x_bus;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] bus(input logic [1:0] sa, input logic sr, input logic sw,
                                        input logic [31:0] d);
        return {28'h0, sa, sr, sw, d};
    endfunction

    function automatic vec_t mk(input logic [1:0] e, input logic [1:0] r, input logic [1:0] w,
                                input logic [63:0] a, input logic [63:0] d, input logic sw,
                                input logic [31:0] srd, input logic [1:0] xw, input logic [1:0] xv,
                                input logic [63:0] xrd, input logic [63:0] xb);
        vec_t v;
        v.en = e; v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.swait = sw; v.srdata = srd;
        v.x_wait = xw; v.x_rv = xv; v.x_rd = xrd; v.x_bus = xb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = '0; rd = '0; wr = '0; addr = '0; wdata = '0; swait = 1'b0; srdata = BAD;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [33:0] rr_seen[$];
        logic [33:0] fp_seen[$];
        logic        fp_w1_low;
        logic        late_valid;

        // Reset state, with reset still asserted
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset_fp_out", {fp_rv, fp_rd}, 66'h0);
        chk("reset_fp_bus", bus(fp_sa, fp_sr, fp_sw, fp_swd), Z64);
        chk("reset_rr_out", {rr_rv, rr_rd}, 66'h0);
        chk("reset_l3_bus", bus(l3_sa, l3_sr, l3_sw, l3_swd), Z64);
        do_reset();

        // Cycle-by-cycle table for the fixed-priority, latency-1 instance
        tbl.push_back(mk(2'b11, 2'b01, 2'b00, {32'h0, 32'h4}, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, Z64, Z64, 1'b0, BAD, 2'b10, 2'b00, Z64, bus(2'd1, 1'b1, 1'b0, 32'h0)));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, Z64, Z64, 1'b0, 32'hDEADBEEF, 2'b10, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, Z64, Z64, 1'b0, BAD, 2'b10, 2'b01, {32'h0, 32'hDEADBEEF}, Z64));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, bus(2'd0, 1'b1, 1'b0, 32'h0)));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, 32'h11112222, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b10, {32'h11112222, 32'h0}, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, {32'h10, 32'h0}, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, Z64, Z64, 1'b0, BAD, 2'b01, 2'b10, Z64, Z64));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b01, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b10, {32'h20, 32'h0}, {32'h77, 32'h0}, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b10, 2'b00, 2'b01, {32'h0, 32'h8}, {32'h0, 32'h99}, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b01, {32'h0, 32'h8}, {32'h0, 32'h12345678}, 1'b1, BAD, 2'b00, 2'b00, Z64, Z64));
        for (int s = 0; s < 4; s++) begin
            tbl.push_back(mk(2'b11, 2'b00, 2'b01, {32'h0, 32'hC}, {32'h0, 32'hCAFEF00D}, (s < 3) ? 1'b1 : 1'b0,
                             BAD, 2'b01, 2'b00, Z64, bus(2'd2, 1'b0, 1'b1, 32'h12345678)));
        end
        tbl.push_back(mk(2'b11, 2'b00, 2'b01, {32'h0, 32'hC}, {32'h0, 32'hCAFEF00D}, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, bus(2'd3, 1'b0, 1'b1, 32'hCAFEF00D)));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, {32'h0, 32'h4}, {32'h0, 32'h55}, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, bus(2'd1, 1'b0, 1'b1, 32'h55)));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, Z64, Z64, 1'b0, BAD, 2'b00, 2'b00, Z64, Z64));

        for (int r = 0; r < tbl.size(); r++) begin
            if (r != 0) @(negedge clk);
            en = tbl[r].en; rd = tbl[r].rd; wr = tbl[r].wr; addr = tbl[r].addr;
            wdata = tbl[r].wdata; swait = tbl[r].swait; srdata = tbl[r].srdata;
            #1;
            chk($sformatf("row%0d_waitrequest", r), 64'(fp_wait), 64'(tbl[r].x_wait));
            chk($sformatf("row%0d_readdatavalid", r), 64'(fp_rv), 64'(tbl[r].x_rv));
            chk($sformatf("row%0d_readdata", r), fp_rd, tbl[r].x_rd);
            chk($sformatf("row%0d_slave_bus", r), bus(fp_sa, fp_sr, fp_sw, fp_swd), tbl[r].x_bus);
        end

        // Both masters write back-to-back: round-robin alternates, fixed priority starves master 1
        do_reset();
        en = 2'b11; wr = 2'b11; addr = {32'h4, 32'h0}; wdata = {32'hB1, 32'hA0}; swait = 1'b0;
        fp_w1_low = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rr_sw) rr_seen.push_back({rr_sa, rr_swd});
            if (fp_sw) fp_seen.push_back({fp_sa, fp_swd});
            if (!fp_wait[1]) fp_w1_low = 1'b1;
            @(negedge clk);
        end
        wr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_write%0d", k), (k < rr_seen.size()) ? 64'(rr_seen[k]) : '1,
                (k % 2 == 0) ? 64'({2'd0, 32'hA0}) : 64'({2'd1, 32'hB1}));
            chk($sformatf("fp_write%0d", k), (k < fp_seen.size()) ? 64'(fp_seen[k]) : '1,
                64'({2'd0, 32'hA0}));
        end
        chk("fp_master1_wait_held", 64'(fp_w1_low), 64'h0);

        // Read latency 3 with one slave stall cycle
        do_reset();
        en = 2'b11; rd = 2'b01; addr = {32'h0, 32'hC}; srdata = BAD;
        #1 chk("l3_accept_wait", 64'(l3_wait), 64'h0);
        @(negedge clk); rd = 2'b00; swait = 1'b1;
        #1 chk("l3_issue_stalled", bus(l3_sa, l3_sr, l3_sw, l3_swd), bus(2'd3, 1'b1, 1'b0, 32'h0));
        @(negedge clk); swait = 1'b0;
        #1 chk("l3_issue_accepted", bus(l3_sa, l3_sr, l3_sw, l3_swd), bus(2'd3, 1'b1, 1'b0, 32'h0));
        @(negedge clk);
        #1 chk("l3_rdwait1_valid", 64'(l3_rv), 64'h0);
        @(negedge clk);
        #1 chk("l3_rdwait2_valid", 64'(l3_rv), 64'h0);
        @(negedge clk); srdata = 32'hA5A5A5A5;
        #1 chk("l3_rdwait3_valid", 64'(l3_rv), 64'h0);
        @(negedge clk); srdata = BAD;
        #1 chk("l3_resp_valid", 64'(l3_rv), 64'h1);
        chk("l3_resp_data", l3_rd, {32'h0, 32'hA5A5A5A5});
        @(negedge clk);
        #1 chk("l3_after_resp_valid", 64'(l3_rv), 64'h0);

        // Reset while the latency-3 instance sits in RDWAIT
        @(negedge clk); rd = 2'b01; addr = Z64;
        @(negedge clk); rd = 2'b00;
        #1 chk("rst_pre_issue", bus(l3_sa, l3_sr, l3_sw, l3_swd), bus(2'd0, 1'b1, 1'b0, 32'h0));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_l3_outputs", {l3_wait, l3_rv, l3_rd}, 68'h0);
        chk("rst_l3_bus", bus(l3_sa, l3_sr, l3_sw, l3_swd), Z64);
        chk("rst_fp_valid", 64'(fp_rv), 64'h0);
        late_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if ((l3_rv | fp_rv | rr_rv) != 2'b00) late_valid = 1'b1;
        end
        chk("rst_no_late_valid", 64'(late_valid), 64'h0);
        @(negedge clk); rd = 2'b11;
        #1;
        chk("rst_rr_first_grant", 64'(rr_wait), 64'h2);
        chk("rst_l3_first_grant", 64'(l3_wait), 64'h2);
        @(negedge clk); rd = 2'b00;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_avs_arbiter.md
Name: sd_avs_arbiter

Overview:
- Parametrised N-master arbiter onto the single driver_sd Avalon slave (4-word register window).
- Supersedes the fixed two-way select with real arbitration:
  - fixed-priority or round-robin grant;
  - per-master enable;
  - slave waitrequest support;
  - configurable slave read latency;
  - out-of-window and disabled-master accesses completed locally.
- Sits between the HDD Avalon master, the BIOS loader and future SD clients, and driver_sd.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- ADDR_W, 32, master address width.
- DATA_W, 32, data width.
- SLAVE_ADDR_W, 2, slave word-address width; window is byte address bits [SLAVE_ADDR_W+1:2].
- READ_LATENCY, 1, cycles from slave read acceptance to valid driver_sd_avs_readdata (1..4).
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_enable  in  NUM_MASTERS  per-master enable; 0 = master routed to local sink
- m_address  in  NUM_MASTERS*ADDR_W  packed byte addresses, master i at [i*ADDR_W +: ADDR_W]
- m_read  in  NUM_MASTERS  read request
- m_write  in  NUM_MASTERS  write request
- m_writedata  in  NUM_MASTERS*DATA_W  packed write data
- m_readdata  out  NUM_MASTERS*DATA_W  packed read data; registered
- m_readdatavalid  out  NUM_MASTERS  one-cycle read response pulse
- m_waitrequest  out  NUM_MASTERS  Avalon waitrequest; combinational
- driver_sd_avs_address  out  SLAVE_ADDR_W  slave word address
- driver_sd_avs_read  out  1  slave read
- driver_sd_avs_write  out  1  slave write
- driver_sd_avs_writedata  out  DATA_W  slave write data
- driver_sd_avs_readdata  in  DATA_W  slave read data
- driver_sd_avs_waitrequest  in  1  slave stall

Behaviour:
- FSM states: IDLE, ISSUE, RDWAIT, RESP. Exactly one transaction is outstanding at a time.
- Request: req[i] = m_read[i] | m_write[i]. If m_read and m_write are both high, the access is treated as a write; the read is ignored.
- Grant, IDLE only:
  - RR_MODE=0: lowest set req index.
  - RR_MODE=1: first set req index searching from last_grant+1 modulo NUM_MASTERS. last_grant resets to NUM_MASTERS-1, so master 0 wins first.
- m_waitrequest[i] = req[i] & ~(state==IDLE & grant==i). A master is accepted in the cycle its waitrequest is low while requesting. The accepted address, data and rw are latched on that edge.
- Local completion applies when m_enable[i]==0 or address bits [ADDR_W-1:SLAVE_ADDR_W+2] != 0:
  - no slave cycle is issued;
  - write is dropped;
  - read returns 0, with m_readdatavalid one cycle after acceptance;
  - FSM goes IDLE->RESP for a read, stays IDLE for a write.
- Slave path, acceptance at cycle T:
  - ISSUE from T+1: read or write held, with latched address[SLAVE_ADDR_W+1:2] and writedata, until driver_sd_avs_waitrequest==0. The slave accepts at cycle S.
  - Write: back to IDLE at S+1.
  - Read: RDWAIT counts READ_LATENCY. readdata is captured at S+READ_LATENCY, then RESP.
- RESP, one cycle:
  - m_readdatavalid[g]=1 and m_readdata slice g = captured data; all other slices are 0.
  - Next state is IDLE, so a new grant is possible the cycle after RESP.
  - Nominal read, READ_LATENCY=1, no stall: accept T, slave read T+1, capture T+2, valid T+3, next accept T+4.
- Slave outputs are 0 outside ISSUE; address and writedata are 0 outside ISSUE.
- Reset values: FSM IDLE, last_grant NUM_MASTERS-1, all m_readdatavalid 0, m_readdata 0, all slave strobes 0.
- Reset mid-operation: the FSM aborts to IDLE; no readdatavalid is ever issued for the aborted read.
- Changing m_enable while a transaction is in flight does not affect it; enable is sampled at acceptance only.
- A request arriving during ISSUE, RDWAIT or RESP stalls (waitrequest high) until IDLE.

Test Plan:
- Single master 0, enabled, read 0x00000004 (READ_LATENCY=1), slave readdata 0xDEADBEEF, no stall -> driver_sd_avs_address=1 read at T+1; m_readdatavalid[0] at T+3 with 0xDEADBEEF; m_readdata slice 1 stays 0.
- Masters 0 and 1 write continuously, RR_MODE=1 -> grants alternate 0,1,0,1; 4 slave writes appear with matching writedata; RR_MODE=0 -> master 0 holds the bus and master 1 waitrequest stays high.
- driver_sd_avs_waitrequest high 3 cycles on a write of 0x12345678 to 0x8 -> write and address=2 held stable 4 cycles; requesting master waitrequest high throughout.
- Master 1 reads 0x00000010 (out of window), and a disabled master 0 reads 0x0 -> no slave strobe; readdatavalid one cycle after acceptance with data 0.
- READ_LATENCY=3 read -> capture exactly 3 cycles after slave acceptance; data 0xA5A5A5A5 returned.
- rst asserted during RDWAIT -> no readdatavalid; all outputs 0 next cycle; first post-reset grant goes to master 0.
